prog_counter: RTL and testbench
===============================

# prog_counter

Parametrised programmable counter for free-running timebases, event counting and timeouts. It generalises the plain always-increment counter with configurable width, a prescaler, up/down direction, a programmable limit and three terminal modes: wrap, saturate and one-shot. It also drives a terminal-count pulse that sequences downstream logic and benches.

## Interface
- WIDTH, 5, counter width in bits
- PRESCALE_W, 4, prescaler compare width
- clk  input  1  clock; all state changes on posedge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  count enable; low freezes counter and prescaler
- clr  input  1  synchronous clear
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value loaded when load=1
- dir  input  1  0 = up, 1 = down
- mode  input  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = treated as wrap
- limit  input  WIDTH  up-count terminal value and down-count reload value
- prescale  input  PRESCALE_W  one tick per prescale+1 enabled cycles
- count  output  WIDTH  current count
- tc  output  1  terminal-count pulse, one cycle
- done  output  1  one-shot finished (level)

## Operation
- **Reset values.** With rst high, asynchronously: count=0, tc=0, done=0, prescaler=0, state=RUN.
- **Tick generation.**
  - pre_cnt increments on each cycle with en=1.
  - tick=1 when en=1 and pre_cnt==prescale; pre_cnt then returns to 0.
  - prescale=0 gives a tick every enabled cycle.
  - clr and load also zero pre_cnt.
- **Priority per cycle:** rst > clr > load > tick.
  - clr: count=0, done=0, state=RUN.
  - load: count=load_val, done=0, state=RUN, no increment that cycle.
- **Terminal value.** The terminal value is limit when dir=0 and 0 when dir=1. Compare is equality only.
- **Ticks that are not terminal events.** A tick in RUN with count != terminal gives count±1 modulo 2^WIDTH.
  - A loaded value above limit therefore counts up to 2^WIDTH-1, wraps to 0 without a tc pulse, then continues toward limit.
- **Terminal events.** A terminal event is a tick in RUN with count == terminal. Action by mode:
  - wrap: count reloads (0 if up, limit if down); tc=1 next cycle.
  - saturate: count holds; tc stays 0.
  - one-shot: count holds; tc=1 next cycle; done=1; state moves to HALTED.
- **FSM states.**
  - RUN: normal counting.
  - HALTED: ticks are ignored. Exit only via clr, load or rst.
- **Mid-run changes.** A change to dir, mode or limit takes effect on the next tick.
  - A mode change while HALTED does not restart counting.
- **tc.** tc is registered and never high two consecutive cycles unless two terminal events occur back-to-back (e.g. limit=0 with prescale=0 in wrap mode gives tc high every cycle).

## Timing
- count updates on the posedge at the end of the tick cycle, i.e. one cycle of latency.
- tc and done rise on the same edge as the terminal-event count update.
- clr/load take effect at the next posedge and override a tick in that same cycle.
- rst asserted mid-operation clears all outputs immediately, with no clock required. Deassertion is synchronised externally; the first tick can occur on the first enabled cycle after release.
- Steady-state tick rate is 1 per (prescale+1) enabled cycles. Cycles with en=0 do not advance pre_cnt.

## Structure
- Package counter_pkg holds:
  - typedef enum mode_e: MODE_WRAP, MODE_SAT, MODE_ONESHOT.
  - typedef enum state_e: ST_RUN, ST_HALTED.
  - Default parameter constants.
- Sub-module tick_prescaler(clk, rst, en, sync_clr, prescale, tick) holds pre_cnt and the compare.
- The top level holds the count register, the terminal compare, the FSM and the tc/done registers.

## Test plan
- **Wrap, up.** WIDTH=5, limit=31, prescale=0, up wrap, en=1 for 40 cycles → count runs 0..31, 0..7; tc high exactly one cycle, coincident with count returning to 0.
- **Prescaler.** prescale=3, limit=9, up wrap → count steps every 4 cycles; tc period is 40 cycles; en low for 5 cycles stretches that period by 5.
- **Saturate, down.** Load 5, dir=1, saturate → count 5,4,3,2,1,0 then holds 0 for 10 further ticks; tc never asserts.
- **One-shot.** Up, limit=9 → count holds 9, done=1, tc one pulse, count frozen while en stays high; clr → count=0, done=0, counting resumes.
- **Priority.** clr+load+tick in one cycle → count=0. load_val=20 with tick → count=20, no increment. Load 20 with limit=9 → counts 20..31, 0..9, with tc only at 9→0.
- **Async reset.** rst pulsed between edges at count=17 with done=1 → count, tc and done go to 0 before the next posedge; counting restarts at 0 after release.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared types and defaults for the programmable counter: terminal modes,
// FSM states and the raw-mode decoder.
package counter_pkg;
    localparam int DEF_WIDTH      = 5;
    localparam int DEF_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // The unused encoding 3 behaves exactly like wrap.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_SAT;
            2'd2:    return MODE_ONESHOT;
            default: return MODE_WRAP;
        endcase
    endfunction
endpackage

// File: rtl/prog_counter_if.sv
// Control and status bundle of prog_counter. The master drives controls and
// observes the count; the slave (the counter) drives count, tc, done and state.
interface prog_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
);
    // No handshake: every control is sampled on each posedge, and the
    // counter's outputs are plain registered levels/pulses.
    logic                  en;
    logic                  clr;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  dir;
    logic [1:0]            mode;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  done;
    state_e                state;

    modport master (
        output en, clr, load, load_val, dir, mode, limit, prescale,
        input  count, tc, done, state
    );

    modport slave (
        input  en, clr, load, load_val, dir, mode, limit, prescale,
        output count, tc, done, state
    );
endinterface

// File: rtl/prog_counter_tick_prescaler.sv
// Divides enabled cycles into ticks: one tick every prescale+1 enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync_clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (sync_clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_W'(1);
            end
        end
    end
endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, limit and wrap/saturate/one-shot
// terminal behaviour; tc is a registered one-cycle pulse, done a level.
module prog_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input logic          clk,
    input logic          rst,
    prog_counter_if.slave bus
);
    state_e           state, state_next;
    logic [WIDTH-1:0] count_q, count_next;
    logic             tc_q, tc_next;
    logic             done_q, done_next;
    logic             tick;
    logic             at_term;
    logic             term_event;
    mode_e            mode_d;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .sync_clr (bus.clr | bus.load),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    assign mode_d     = decode_mode(bus.mode);
    assign at_term    = bus.dir ? (count_q == '0) : (count_q == bus.limit);
    assign term_event = tick && (state == ST_RUN) && at_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.clr || bus.load) begin
            state_next = ST_RUN;
        end else if (term_event && mode_d == MODE_ONESHOT) begin
            state_next = ST_HALTED;
        end
    end

    // Ticks arriving while HALTED fall through every branch and change nothing.
    always_comb begin
        count_next = count_q;
        tc_next    = 1'b0;
        done_next  = done_q;
        if (bus.clr) begin
            count_next = '0;
            done_next  = 1'b0;
        end else if (bus.load) begin
            count_next = bus.load_val;
            done_next  = 1'b0;
        end else if (term_event) begin
            case (mode_d)
                MODE_SAT: begin
                    count_next = count_q;
                end
                MODE_ONESHOT: begin
                    tc_next   = 1'b1;
                    done_next = 1'b1;
                end
                default: begin
                    count_next = bus.dir ? bus.limit : '0;
                    tc_next    = 1'b1;
                end
            endcase
        end else if (tick && state == ST_RUN) begin
            count_next = bus.dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_next;
            tc_q    <= tc_next;
            done_q  <= done_next;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;
    assign bus.state = state;
endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: each scenario task drives the counter and
// checks count/tc/done against hand-derived sequences.
module tb_prog_counter;
    import counter_pkg::*;

    localparam int WIDTH      = 5;
    localparam int PRESCALE_W = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    prog_counter_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

    prog_counter #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 ns past it before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.dir = 1'b0; bus.mode = 2'd0; bus.limit = '0; bus.prescale = '0;
        step();
        step();
        n_cmp++;
        if (bus.count !== 5'd0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: count=%0d tc=%b done=%b, want 0 0 0", bus.count, bus.tc, bus.done);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [WIDTH-1:0] exp_c;
        bus.limit = 5'd31; bus.prescale = 4'd0; bus.dir = 1'b0; bus.mode = 2'd0; bus.en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_c = WIDTH'(k % 32);
            n_cmp++;
            if (bus.count !== exp_c || bus.tc !== (k == 32)) begin
                n_bad++;
                $display("FAIL wrap_up k=%0d: count=%0d tc=%b, want %0d %b", k, bus.count, bus.tc, exp_c, (k == 32));
            end
        end
    endtask

    task automatic test_prescaler();
        logic [WIDTH-1:0] exp_c;
        int               hit;
        bus.prescale = 4'd3; bus.limit = 5'd9; bus.dir = 1'b0; bus.mode = 2'd0; bus.en = 1'b1;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            step();
            exp_c = WIDTH'((k / 4) % 10);
            n_cmp++;
            if (bus.count !== exp_c || bus.tc !== (k % 40 == 0)) begin
                n_bad++;
                $display("FAIL prescaler k=%0d: count=%0d tc=%b, want %0d %b", k, bus.count, bus.tc, exp_c, (k % 40 == 0));
            end
        end
        // Five disabled cycles in the middle of a period push the next tc out by five.
        hit = 0;
        for (int i = 1; i <= 100; i++) begin
            bus.en = !(i >= 11 && i <= 15);
            step();
            if (bus.tc === 1'b1) begin
                hit = i;
                break;
            end
        end
        bus.en = 1'b1;
        n_cmp++;
        if (hit != 45) begin
            n_bad++;
            $display("FAIL prescaler_stretch: tc after %0d cycles, want 45", hit);
        end
    endtask

    task automatic test_saturate_down();
        logic [WIDTH-1:0] exp_c;
        bus.prescale = 4'd0; bus.dir = 1'b1; bus.mode = 2'd1; bus.en = 1'b1;
        bus.load = 1'b1; bus.load_val = 5'd5;
        step();
        bus.load = 1'b0;
        n_cmp++;
        if (bus.count !== 5'd5) begin
            n_bad++;
            $display("FAIL sat_load: count=%0d, want 5", bus.count);
        end
        for (int k = 1; k <= 15; k++) begin
            step();
            exp_c = (k < 5) ? WIDTH'(5 - k) : 5'd0;
            n_cmp++;
            if (bus.count !== exp_c || bus.tc !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_down k=%0d: count=%0d tc=%b, want %0d 0", k, bus.count, bus.tc, exp_c);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [WIDTH-1:0] exp_c;
        bus.dir = 1'b0; bus.mode = 2'd2; bus.limit = 5'd9; bus.prescale = 4'd0; bus.en = 1'b1;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            exp_c = (k <= 9) ? WIDTH'(k) : 5'd9;
            n_cmp++;
            if (bus.count !== exp_c || bus.tc !== (k == 10) || bus.done !== (k >= 10)) begin
                n_bad++;
                $display("FAIL oneshot k=%0d: count=%0d tc=%b done=%b, want %0d %b %b",
                         k, bus.count, bus.tc, bus.done, exp_c, (k == 10), (k >= 10));
            end
        end
        n_cmp++;
        if (bus.state !== ST_HALTED) begin
            n_bad++;
            $display("FAIL oneshot_state: state=%0d, want HALTED", bus.state);
        end
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        n_cmp++;
        if (bus.count !== 5'd0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_clr: count=%0d done=%b, want 0 0", bus.count, bus.done);
        end
        step();
        n_cmp++;
        if (bus.count !== 5'd1) begin
            n_bad++;
            $display("FAIL oneshot_resume: count=%0d, want 1", bus.count);
        end
    endtask

    task automatic test_priority();
        logic [WIDTH-1:0] exp_c;
        bus.mode = 2'd0; bus.limit = 5'd9; bus.dir = 1'b0; bus.prescale = 4'd0; bus.en = 1'b1;
        bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 5'd7;
        step();
        bus.clr = 1'b0;
        n_cmp++;
        if (bus.count !== 5'd0) begin
            n_bad++;
            $display("FAIL prio_clr_load: count=%0d, want 0", bus.count);
        end
        bus.load_val = 5'd20;
        step();
        bus.load = 1'b0;
        n_cmp++;
        if (bus.count !== 5'd20) begin
            n_bad++;
            $display("FAIL prio_load_tick: count=%0d, want 20", bus.count);
        end
        // Above the limit: runs to 31, wraps silently, then hits the real terminal at 9.
        for (int k = 1; k <= 22; k++) begin
            step();
            exp_c = (k <= 21) ? WIDTH'((20 + k) % 32) : 5'd0;
            n_cmp++;
            if (bus.count !== exp_c || bus.tc !== (k == 22)) begin
                n_bad++;
                $display("FAIL prio_above_limit k=%0d: count=%0d tc=%b, want %0d %b", k, bus.count, bus.tc, exp_c, (k == 22));
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.mode = 2'd0; bus.limit = 5'd0; bus.dir = 1'b0; bus.prescale = 4'd0; bus.en = 1'b1;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++;
            if (bus.count !== 5'd0 || bus.tc !== 1'b1) begin
                n_bad++;
                $display("FAIL back_to_back k=%0d: count=%0d tc=%b, want 0 1", k, bus.count, bus.tc);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.mode = 2'd2; bus.limit = 5'd17; bus.dir = 1'b0; bus.prescale = 4'd0; bus.en = 1'b1;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        for (int k = 1; k <= 18; k++) step();
        n_cmp++;
        if (bus.count !== 5'd17 || bus.tc !== 1'b1 || bus.done !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: count=%0d tc=%b done=%b, want 17 1 1", bus.count, bus.tc, bus.done);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.count !== 5'd0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: count=%0d tc=%b done=%b, want 0 0 0", bus.count, bus.tc, bus.done);
        end
        #1 rst = 1'b0;
        bus.mode = 2'd0; bus.limit = 5'd31;
        step();
        n_cmp++;
        if (bus.count !== 5'd1 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_restart: count=%0d done=%b, want 1 0", bus.count, bus.done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_wrap_up();
        test_prescaler();
        test_saturate_down();
        test_oneshot();
        test_priority();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
